// File: rtl/tcp_vlg_keepalive_fsm.sv
// Per-connection TCP keep-alive engine: idle timer, periodic probes, disconnect
// request after TRIES unanswered probes. Timers advance on a prescaled tick.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_OFF   | disabled or not connected; outputs, timer, prescaler cleared
// S_IDLE  | counting RX silence towards the first probe
// S_PROBE | probe requested (send=1), waiting for TX to report it sent
// S_WAIT  | counting the interval after a probe
// S_DCN   | too many unanswered probes; dcn held until leave or reset
module tcp_vlg_keepalive_fsm #(
  parameter int TICK_DIV       = 125000,
  parameter int IDLE_TICKS     = 7200,
  parameter int INTERVAL_TICKS = 75,
  parameter int TRIES          = 9,
  parameter int ENABLE         = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         connected,
  input  logic [15:0]                  loc_port,
  input  logic [15:0]                  rem_port,
  input  logic                         rx_val,
  input  logic [15:0]                  rx_src_port,
  input  logic [15:0]                  rx_dst_port,
  output logic                         send,
  input  logic                         sent,
  output logic                         dcn,
  output logic [$clog2(TRIES+1)-1:0]   probes,
  output logic                         active
);

  localparam int TMAX = (IDLE_TICKS > INTERVAL_TICKS) ? IDLE_TICKS : INTERVAL_TICKS;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW   = $clog2(TRIES + 1);

  localparam logic [TW-1:0] IDLE_LAST  = TW'(IDLE_TICKS - 1);
  localparam logic [TW-1:0] INTVL_LAST = TW'(INTERVAL_TICKS - 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] TRIES_C    = CW'(TRIES);

  typedef enum logic [2:0] {S_OFF, S_IDLE, S_PROBE, S_WAIT, S_DCN} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [PW-1:0] presc;
  logic          match;
  logic          tick;
  logic          leave;

  assign match = rx_val && (rx_dst_port == loc_port) && (rx_src_port == rem_port);
  assign tick  = (presc == PRESC_LAST);
  assign leave = !connected || !en || (ENABLE == 0);

  always_ff @(posedge clk) begin
    if (rst || leave) begin
      state  <= S_OFF;
      send   <= 1'b0;
      dcn    <= 1'b0;
      probes <= '0;
      timer  <= '0;
      presc  <= '0;
      active <= 1'b0;
    end else begin
      if (state == S_OFF || tick) presc <= '0;
      else                        presc <= presc + 1'b1;

      // A matching segment proves the peer alive; it beats tick expiry and sent.
      if (match && (state == S_IDLE || state == S_PROBE || state == S_WAIT)) begin
        state  <= S_IDLE;
        timer  <= '0;
        probes <= '0;
        send   <= 1'b0;
        active <= 1'b0;
      end else begin
        case (state)
          S_OFF: begin
            state  <= S_IDLE;
            timer  <= '0;
            probes <= '0;
          end
          S_IDLE: begin
            if (tick) begin
              if (timer == IDLE_LAST) begin
                state  <= S_PROBE;
                timer  <= '0;
                send   <= 1'b1;
                active <= 1'b1;
              end else begin
                timer <= timer + 1'b1;
              end
            end
          end
          S_PROBE: begin
            if (sent) begin
              state <= S_WAIT;
              send  <= 1'b0;
              if (probes != TRIES_C) probes <= probes + 1'b1;
            end
          end
          S_WAIT: begin
            if (tick) begin
              if (timer == INTVL_LAST) begin
                timer <= '0;
                if (probes == TRIES_C) begin
                  state  <= S_DCN;
                  dcn    <= 1'b1;
                  active <= 1'b0;
                end else begin
                  state <= S_PROBE;
                  send  <= 1'b1;
                end
              end else begin
                timer <= timer + 1'b1;
              end
            end
          end
          S_DCN: begin
            send <= 1'b0;
            dcn  <= 1'b1;
          end
          default: state <= S_OFF;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tcp_vlg_keepalive_fsm.sv
// Directed bench: expectations are queued per cycle when stimulus is planned and
// compared against the DUT outputs when that cycle arrives.
module tb_tcp_vlg_keepalive_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: TICK_DIV=1, IDLE=10, INTERVAL=4, TRIES=3
  logic        a_rst, a_en, a_con, a_rx_val, a_sent;
  logic [15:0] a_src, a_dst;
  logic        a_send, a_dcn, a_active;
  logic [1:0]  a_probes;

  // DUT B: TICK_DIV=4, IDLE=3, INTERVAL=2, TRIES=2
  logic        b_rst, b_en, b_con, b_rx_val, b_sent;
  logic [15:0] b_src, b_dst;
  logic        b_send, b_dcn, b_active;
  logic [1:0]  b_probes;

  localparam logic [15:0] LOC = 16'd80;
  localparam logic [15:0] REM = 16'd1234;

  tcp_vlg_keepalive_fsm #(.TICK_DIV(1), .IDLE_TICKS(10), .INTERVAL_TICKS(4),
                          .TRIES(3), .ENABLE(1)) dut_a (
    .clk(clk), .rst(a_rst), .en(a_en), .connected(a_con),
    .loc_port(LOC), .rem_port(REM), .rx_val(a_rx_val),
    .rx_src_port(a_src), .rx_dst_port(a_dst),
    .send(a_send), .sent(a_sent), .dcn(a_dcn), .probes(a_probes), .active(a_active));

  tcp_vlg_keepalive_fsm #(.TICK_DIV(4), .IDLE_TICKS(3), .INTERVAL_TICKS(2),
                          .TRIES(2), .ENABLE(1)) dut_b (
    .clk(clk), .rst(b_rst), .en(b_en), .connected(b_con),
    .loc_port(LOC), .rem_port(REM), .rx_val(b_rx_val),
    .rx_src_port(b_src), .rx_dst_port(b_dst),
    .send(b_send), .sent(b_sent), .dcn(b_dcn), .probes(b_probes), .active(b_active));

  typedef struct {
    string      tag;
    int         cyc;
    int         sel;
    logic [4:0] vec;  // {send, dcn, active, probes}
  } exp_t;

  exp_t       q[$];
  exp_t       e;
  logic [4:0] obs;
  int         cnt = 0;
  int         t0 = 0;
  int         vectors = 0;
  int         miscompares = 0;
  bit         flush = 1'b0;

  always @(posedge clk) cnt <= cnt + 1;

  always @(negedge clk) begin
    while (q.size() > 0 && (q[0].cyc <= cnt || flush)) begin
      e   = q.pop_front();
      obs = e.sel != 0 ? {b_send, b_dcn, b_active, b_probes}
                       : {a_send, a_dcn, a_active, a_probes};
      vectors++;
      assert (obs === e.vec && e.cyc == cnt) else begin
        miscompares++;
        $error("FAIL %s: cycle %0d got send/dcn/active/probes=%b, need %b at cycle %0d",
               e.tag, cnt, obs, e.vec, e.cyc);
      end
    end
  end

  task automatic ex(input string tag, input int sel, input int rel,
                    input logic s, input logic d, input logic a, input logic [1:0] p);
    q.push_back('{tag, t0 + rel, sel, {s, d, a, p}});
  endtask

  task automatic wait_to(input int rel);
    while (cnt - t0 < rel) @(negedge clk);
  endtask

  task automatic pulse_sent_a(input int rel);
    wait_to(rel); a_sent = 1'b1;
    wait_to(rel + 1); a_sent = 1'b0;
  endtask

  task automatic pulse_rx_a(input int rel, input logic [15:0] src, input logic [15:0] dst);
    wait_to(rel); a_rx_val = 1'b1; a_src = src; a_dst = dst;
    wait_to(rel + 1); a_rx_val = 1'b0;
  endtask

  // Drop connected long enough to reach OFF, then reconnect; cycle 1 is IDLE.
  task automatic start_a();
    a_con = 1'b0; a_en = 1'b1; a_rx_val = 1'b0; a_sent = 1'b0;
    @(negedge clk); @(negedge clk);
    a_con = 1'b1;
    t0 = cnt;
  endtask

  initial begin
    a_rst = 1'b1; a_en = 1'b1; a_con = 1'b1; a_rx_val = 1'b0; a_sent = 1'b0;
    a_src = REM; a_dst = LOC;
    b_rst = 1'b1; b_en = 1'b1; b_con = 1'b1; b_rx_val = 1'b0; b_sent = 1'b0;
    b_src = REM; b_dst = LOC;

    // Reset dominates enable/connected
    @(negedge clk);
    t0 = cnt;
    ex("rst_a", 0, 1, 0, 0, 0, 2'd0);
    ex("rst_b", 1, 1, 0, 0, 0, 2'd0);
    ex("rst_a2", 0, 2, 0, 0, 0, 2'd0);
    ex("rst_b2", 1, 2, 0, 0, 0, 2'd0);
    wait_to(3);
    if ({a_send, a_dcn, a_active, a_probes, b_send, b_dcn, b_active, b_probes} !== 10'd0) begin
      miscompares++;
      $error("FAIL reset_state: a=%b b=%b, need all zero",
             {a_send, a_dcn, a_active, a_probes}, {b_send, b_dcn, b_active, b_probes});
    end
    a_rst = 1'b0; b_rst = 1'b0; b_con = 1'b0;

    // Probe timing to disconnect; sent and match in DCN are ignored; leave clears dcn
    start_a();
    ex("idle_c1", 0, 1, 0, 0, 0, 2'd0);
    ex("idle_c10", 0, 10, 0, 0, 0, 2'd0);
    ex("send1_c11", 0, 11, 1, 0, 1, 2'd0);
    ex("send1_held", 0, 13, 1, 0, 1, 2'd0);
    ex("wait1_p1", 0, 14, 0, 0, 1, 2'd1);
    ex("wait1_end", 0, 17, 0, 0, 1, 2'd1);
    ex("send2_c18", 0, 18, 1, 0, 1, 2'd1);
    ex("wait2_p2", 0, 21, 0, 0, 1, 2'd2);
    ex("send3_c25", 0, 25, 1, 0, 1, 2'd2);
    ex("wait3_p3", 0, 28, 0, 0, 1, 2'd3);
    ex("wait3_end", 0, 31, 0, 0, 1, 2'd3);
    ex("dcn_c32", 0, 32, 0, 1, 0, 2'd3);
    ex("dcn_sticky", 0, 40, 0, 1, 0, 2'd3);
    ex("dcn_leave", 0, 42, 0, 0, 0, 2'd0);
    pulse_sent_a(13);
    pulse_sent_a(20);
    pulse_sent_a(27);
    wait_to(33);
    if ({a_send, a_dcn, a_active, a_probes} !== 5'b01011) begin
      miscompares++;
      $error("FAIL expired_wait: got send/dcn/active/probes=%b, need 01011",
             {a_send, a_dcn, a_active, a_probes});
    end
    pulse_sent_a(35);
    pulse_rx_a(36, REM, LOC);
    wait_to(41); a_con = 1'b0;
    wait_to(43);

    // Answered probe in WAIT, then a match while in PROBE
    start_a();
    ex("ans_send1", 0, 11, 1, 0, 1, 2'd0);
    ex("ans_wait", 0, 15, 0, 0, 1, 2'd1);
    ex("ans_idle", 0, 16, 0, 0, 0, 2'd0);
    ex("ans_c25", 0, 25, 0, 0, 0, 2'd0);
    ex("ans_send2", 0, 26, 1, 0, 1, 2'd0);
    ex("probe_match", 0, 28, 0, 0, 0, 2'd0);
    pulse_sent_a(13);
    pulse_rx_a(15, REM, LOC);
    pulse_rx_a(27, REM, LOC);
    wait_to(29);

    // Non-matching traffic every 3 cycles leaves timing untouched
    start_a();
    ex("nm_send1", 0, 11, 1, 0, 1, 2'd0);
    ex("nm_p1", 0, 14, 0, 0, 1, 2'd1);
    ex("nm_send2", 0, 18, 1, 0, 1, 2'd1);
    ex("nm_send3", 0, 25, 1, 0, 1, 2'd2);
    ex("nm_p3", 0, 28, 0, 0, 1, 2'd3);
    ex("nm_dcn", 0, 32, 0, 1, 0, 2'd3);
    for (int r = 1; r <= 33; r++) begin
      wait_to(r);
      a_rx_val = (r % 3 == 0);
      a_src    = (r % 6 == 0) ? REM : 16'd1235;
      a_dst    = (r % 6 == 0) ? 16'd81 : LOC;
      a_sent   = (r == 13 || r == 20 || r == 27);
    end
    wait_to(34);
    a_rx_val = 1'b0; a_sent = 1'b0; a_src = REM; a_dst = LOC;

    // Match and sent in the same cycle: match wins, probes not incremented
    start_a();
    ex("sim_send", 0, 13, 1, 0, 1, 2'd0);
    ex("sim_idle", 0, 14, 0, 0, 0, 2'd0);
    ex("sim_c23", 0, 23, 0, 0, 0, 2'd0);
    ex("sim_send2", 0, 24, 1, 0, 1, 2'd0);
    wait_to(13); a_sent = 1'b1; a_rx_val = 1'b1;
    wait_to(14); a_sent = 1'b0; a_rx_val = 1'b0;
    wait_to(25);

    // Connection drop while in PROBE
    start_a();
    ex("lv_probe", 0, 19, 1, 0, 1, 2'd1);
    ex("lv_off", 0, 20, 0, 0, 0, 2'd0);
    pulse_sent_a(13);
    wait_to(19); a_con = 1'b0;
    wait_to(21);

    // Runtime disable in IDLE: no probe ever
    start_a();
    ex("dis_c6", 0, 6, 0, 0, 0, 2'd0);
    ex("dis_c11", 0, 11, 0, 0, 0, 2'd0);
    ex("dis_c20", 0, 20, 0, 0, 0, 2'd0);
    ex("dis_c30", 0, 30, 0, 0, 0, 2'd0);
    wait_to(5); a_en = 1'b0;
    wait_to(31); a_en = 1'b1;

    // Prescaler DUT: first send 12 clocks after IDLE; reset mid-WAIT
    @(negedge clk);
    b_con = 1'b1;
    t0 = cnt;
    ex("pre_c12", 1, 12, 0, 0, 0, 2'd0);
    ex("pre_send", 1, 13, 1, 0, 1, 2'd0);
    ex("pre_wait", 1, 17, 0, 0, 1, 2'd1);
    ex("pre_rst", 1, 18, 0, 0, 0, 2'd0);
    ex("pre_c30", 1, 30, 0, 0, 0, 2'd0);
    ex("pre_resend", 1, 31, 1, 0, 1, 2'd0);
    wait_to(14); b_sent = 1'b1;
    wait_to(15); b_sent = 1'b0;
    wait_to(17); b_rst = 1'b1;
    wait_to(18); b_rst = 1'b0;
    wait_to(32);

    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      flush = 1'b1;
      @(negedge clk);
      @(negedge clk);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    if (miscompares != 0) $error("FAIL: %0d miscompares", miscompares);
    $finish;
  end

endmodule
